rx_link_fault_ctrl: RTL and testbench

//  Receive-side link fault sequencer for the 10G RS (IEEE 802.3ae cl.46 style).

---
 rtl/rx_link_fault_ctrl_pkg.sv | 23 ++
 rtl/rx_sat_counter.sv | 25 ++
 rtl/rx_link_fault_ctrl.sv | 126 ++++++++++++
 tb/tb_rx_link_fault_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rx_link_fault_ctrl_pkg.sv
// rtl/rx_link_fault_ctrl_pkg.sv - shared link codes, state encodings and helpers for the rx link fault sequencer
package rx_link_fault_ctrl_pkg;

   // Link status codes, shared with the tx RS block
   localparam logic [1:0] LINK_OK     = 2'b00;
   localparam logic [1:0] LINK_LOCAL  = 2'b01;
   localparam logic [1:0] LINK_REMOTE = 2'b10;

   // Sequencer state encodings
   localparam logic [1:0] ST_INIT  = 2'b00;
   localparam logic [1:0] ST_COUNT = 2'b01;
   localparam logic [1:0] ST_FAULT = 2'b10;

   // Fault sequence type as tracked in last_type
   localparam logic TYPE_LOCAL  = 1'b0;
   localparam logic TYPE_REMOTE = 1'b1;

   // Map a sequence type onto the link status code it raises
   function automatic logic [1:0] type_to_link(input logic seq_type);
      return (seq_type == TYPE_REMOTE) ? LINK_REMOTE : LINK_LOCAL;
   endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// rtl/rx_sat_counter.sv - saturating event counter with synchronous clear
module rx_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             rxclk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Count up on inc, stick at all-ones, clear wins over increment
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/rx_link_fault_ctrl.sv
// rtl/rx_link_fault_ctrl.sv - rx link fault sequencer: link status, tx RS forcing, rx frame gating, fault counts
module rx_link_fault_ctrl
   import rx_link_fault_ctrl_pkg::*;
#(
   parameter int FAULT_SEQ_THRESH = 4,
   parameter int COL_WINDOW       = 128,
   parameter int CNT_W            = 16
) (
   input  logic             rxclk,
   input  logic             reset,
   input  logic             local_fault,
   input  logic             remote_fault,
   input  logic             cfg_fault_dis,
   input  logic             cnt_clr,
   output logic [1:0]       link_fault,
   output logic             tx_force_rf,
   output logic             tx_force_idle,
   output logic             rx_frame_en,
   output logic [CNT_W-1:0] lf_event_cnt,
   output logic [CNT_W-1:0] rf_event_cnt
);

   localparam logic [3:0] THRESH_C = 4'(FAULT_SEQ_THRESH);
   localparam logic [7:0] WIN_LAST = 8'(COL_WINDOW - 1);

   logic [1:0] state;
   logic [1:0] link_q;
   logic [3:0] seq_cnt;
   logic [7:0] col_cnt;
   logic       last_type;

   logic       seq_valid;
   logic       seq_type;
   logic       same_type;
   logic       qualify;
   logic       lf_inc;
   logic       rf_inc;

   // Both fault inputs in one column resolve to LOCAL
   assign seq_valid = local_fault | remote_fault;
   assign seq_type  = local_fault ? TYPE_LOCAL : TYPE_REMOTE;
   assign same_type = (seq_type == last_type);

   // The column that brings a same-type run up to threshold while counting
   assign qualify = !cfg_fault_dis && (state == ST_COUNT) && seq_valid && same_type
                    && ((seq_cnt + 4'd1) == THRESH_C);
   assign lf_inc  = qualify && (seq_type == TYPE_LOCAL);
   assign rf_inc  = qualify && (seq_type == TYPE_REMOTE);

   // Sequencer: track run length of one fault type and the fault-free gap since the last sequence
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         state     <= ST_INIT;
         link_q    <= LINK_OK;
         seq_cnt   <= 4'd0;
         col_cnt   <= 8'd0;
         last_type <= TYPE_LOCAL;
      end else if (cfg_fault_dis) begin
         state  <= ST_INIT;
         link_q <= LINK_OK;
      end else begin
         case (state)
            ST_INIT: begin
               link_q <= LINK_OK;
               if (seq_valid) begin
                  last_type <= seq_type;
                  seq_cnt   <= 4'd1;
                  col_cnt   <= 8'd0;
                  state     <= ST_COUNT;
               end
            end
            ST_COUNT, ST_FAULT: begin
               if (seq_valid && same_type) begin
                  col_cnt <= 8'd0;
                  if (state == ST_COUNT) begin
                     seq_cnt <= seq_cnt + 4'd1;
                     if (qualify) begin
                        state  <= ST_FAULT;
                        link_q <= type_to_link(seq_type);
                     end
                  end
               end else if (seq_valid) begin
                  // A new type restarts qualification; any existing fault stays reported
                  last_type <= seq_type;
                  seq_cnt   <= 4'd1;
                  col_cnt   <= 8'd0;
                  state     <= ST_COUNT;
               end else begin
                  col_cnt <= col_cnt + 8'd1;
                  if (col_cnt == WIN_LAST) begin
                     state  <= ST_INIT;
                     link_q <= LINK_OK;
                  end
               end
            end
            default: begin
               state  <= ST_INIT;
               link_q <= LINK_OK;
            end
         endcase
      end
   end

   rx_sat_counter #(.CNT_W(CNT_W)) u_lf_cnt (
      .rxclk (rxclk),
      .reset (reset),
      .inc   (lf_inc),
      .clr   (cnt_clr),
      .cnt   (lf_event_cnt)
   );

   rx_sat_counter #(.CNT_W(CNT_W)) u_rf_cnt (
      .rxclk (rxclk),
      .reset (reset),
      .inc   (rf_inc),
      .clr   (cnt_clr),
      .cnt   (rf_event_cnt)
   );

   // Tx forcing and rx gating follow the registered link status only
   assign link_fault    = link_q;
   assign tx_force_rf   = (link_q == LINK_LOCAL);
   assign tx_force_idle = (link_q == LINK_REMOTE);
   assign rx_frame_en   = (link_q == LINK_OK);

endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
// tb/tb_rx_link_fault_ctrl.sv - scoreboard bench for rx_link_fault_ctrl
module tb_rx_link_fault_ctrl;

   localparam int CNT_W = 2;

   logic             rxclk = 1'b0;
   logic             reset = 1'b1;
   logic             local_fault = 1'b0;
   logic             remote_fault = 1'b0;
   logic             cfg_fault_dis = 1'b0;
   logic             cnt_clr = 1'b0;
   logic [1:0]       link_fault;
   logic             tx_force_rf;
   logic             tx_force_idle;
   logic             rx_frame_en;
   logic [CNT_W-1:0] lf_event_cnt;
   logic [CNT_W-1:0] rf_event_cnt;

   typedef struct {
      logic       chk;
      logic [1:0] lk;
      int         lf;
      int         rf;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   rx_link_fault_ctrl #(
      .FAULT_SEQ_THRESH (4),
      .COL_WINDOW       (128),
      .CNT_W            (CNT_W)
   ) dut (
      .rxclk         (rxclk),
      .reset         (reset),
      .local_fault   (local_fault),
      .remote_fault  (remote_fault),
      .cfg_fault_dis (cfg_fault_dis),
      .cnt_clr       (cnt_clr),
      .link_fault    (link_fault),
      .tx_force_rf   (tx_force_rf),
      .tx_force_idle (tx_force_idle),
      .rx_frame_en   (rx_frame_en),
      .lf_event_cnt  (lf_event_cnt),
      .rf_event_cnt  (rf_event_cnt)
   );

   always #5 rxclk = ~rxclk;

   task automatic compare(input string nm, input logic [1:0] lk, input int lf, input int rf);
      logic exp_rf_f, exp_idle, exp_en;
      exp_rf_f = (lk == 2'b01);
      exp_idle = (lk == 2'b10);
      exp_en   = (lk == 2'b00);
      n_cmp++;
      if (link_fault !== lk || tx_force_rf !== exp_rf_f || tx_force_idle !== exp_idle ||
          rx_frame_en !== exp_en || int'(lf_event_cnt) != lf || int'(rf_event_cnt) != rf) begin
         n_bad++;
         $display("FAIL %s: got link=%b frc_rf=%b frc_idle=%b frm_en=%b lf=%0d rf=%0d, want link=%b frc_rf=%b frc_idle=%b frm_en=%b lf=%0d rf=%0d",
                  nm, link_fault, tx_force_rf, tx_force_idle, rx_frame_en, lf_event_cnt, rf_event_cnt,
                  lk, exp_rf_f, exp_idle, exp_en, lf, rf);
      end
   endtask

   // One column: drive at negedge, queue the expected state after the next posedge
   task automatic col(input logic l, input logic r, input logic dis, input logic clr,
                      input logic chk, input logic [1:0] lk, input int lf, input int rf, input string nm);
      exp_t e;
      @(negedge rxclk);
      local_fault   = l;
      remote_fault  = r;
      cfg_fault_dis = dis;
      cnt_clr       = clr;
      e.chk = chk; e.lk = lk; e.lf = lf; e.rf = rf; e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: after each active edge, pop and check the matching expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge rxclk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) compare(e.nm, e.lk, e.lf, e.rf);
         end
      end
   end

   initial begin
      int sat_lf[6];
      int sat_rf[6];
      logic [1:0] lk_now, lk_prev;
      int plf, prf;
      sat_lf = '{2, 2, 3, 3, 3, 3};
      sat_rf = '{1, 2, 2, 3, 3, 3};

      #1;
      compare("rst_init", 2'b00, 0, 0);
      @(negedge rxclk);
      reset = 1'b0;

      // 4 LOCAL back-to-back
      for (int i = 0; i < 4; i++)
         col(1, 0, 0, 0, 1, (i == 3) ? 2'b01 : 2'b00, (i == 3) ? 1 : 0, 0, "t1_local4");

      // LOCAL fault, then 4 REMOTE: old fault persists until REMOTE qualifies
      for (int i = 0; i < 4; i++)
         col(0, 1, 0, 0, 1, (i == 3) ? 2'b10 : 2'b01, 1, (i == 3) ? 1 : 0, "t4_l_to_r");

      // Fault-free window
      for (int i = 0; i < 127; i++)
         col(0, 0, 0, 0, (i == 0 || i == 126), 2'b10, 1, 1, "t3_idle127");
      col(0, 0, 0, 0, 1, 2'b00, 1, 1, "t3_idle128");

      // 3 REMOTE, 1 LOCAL, 3 REMOTE: no fault
      for (int i = 0; i < 7; i++)
         col((i == 3), (i != 3), 0, 0, 1, 2'b00, 1, 1, "t2_type_restart");

      // Alternating fault types drive both counters into saturation
      for (int k = 0; k < 6; k++) begin
         lk_now  = (k % 2 == 0) ? 2'b01 : 2'b10;
         lk_prev = (k == 0) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
         plf     = (k == 0) ? 1 : sat_lf[k-1];
         prf     = (k == 0) ? 1 : sat_rf[k-1];
         for (int i = 0; i < 4; i++)
            col((k % 2 == 0), (k % 2 == 1), 0, 0, (i >= 2),
                (i == 3) ? lk_now : lk_prev,
                (i == 3) ? sat_lf[k] : plf,
                (i == 3) ? sat_rf[k] : prf, "t6_saturate");
      end

      // Clear in the same cycle as a LOCAL qualification
      for (int i = 0; i < 4; i++)
         col(1, 0, 0, (i == 3), (i == 3), 2'b01, 0, 0, "t6_clr_vs_inc");

      // Fault disable mid-fault: link OK, counters frozen
      for (int i = 0; i < 4; i++)
         col(0, 1, 1, 0, 1, 2'b00, 0, 0, "t6_fault_dis");

      // Both inputs high resolve to LOCAL
      for (int i = 0; i < 4; i++)
         col(1, 1, 0, 0, 1, (i == 3) ? 2'b01 : 2'b00, (i == 3) ? 1 : 0, 0, "t5_both_local");

      // Enter COUNT with REMOTE while LOCAL fault still reported
      for (int i = 0; i < 2; i++)
         col(0, 1, 0, 0, 1, 2'b01, 1, 0, "t5_persist");

      // Asynchronous reset mid-COUNT
      @(negedge rxclk);
      local_fault  = 1'b0;
      remote_fault = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      compare("t5_async_rst", 2'b00, 0, 0);
      @(negedge rxclk);
      reset = 1'b0;

      col(1, 0, 0, 0, 1, 2'b00, 0, 0, "post_rst");
      col(0, 0, 0, 0, 0, 2'b00, 0, 0, "tail");

      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(posedge rxclk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
